nonce_dispatcher: RTL and testbench

Parametrised nonce-range dispatcher between `work_handler` and an array of `NUM_CORES` lock-step hash lanes. It slices a job's nonce range across the lanes and bounds in-flight batches. It compares each returned hash against the job target and buffers winning nonces in a result FIFO for `serial_handler`. Unlike the single-core flow, it supports N lanes, range exhaustion detection and in-flight flushing on restart.

---
 rtl/miner_pkg.sv | 36 +++
 rtl/result_fifo.sv | 54 +++++
 rtl/nonce_dispatcher.sv | 196 +++++++++++++++++++
 tb/tb_nonce_dispatcher.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/miner_pkg.sv
// Shared types and helpers for the nonce dispatcher: FSM states, width
// defaults, the hash/target comparison and a lowest-lane priority pick.
package miner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int unsigned DEF_NONCE_W = 32;
  localparam int unsigned DEF_HASH_W  = 32;
  localparam int unsigned MAX_LANES   = 16;
  localparam int unsigned MAX_HASH_W  = 64;

  function automatic logic hash_le_target(input logic [MAX_HASH_W-1:0] hash,
                                          input logic [MAX_HASH_W-1:0] target);
    return hash <= target;
  endfunction

  function automatic logic [3:0] lowest_set(input logic [MAX_LANES-1:0] vec);
    logic [3:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      if (vec[i] && !found) begin
        idx   = 4'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous show-ahead FIFO holding winning nonces; clear has priority
// over push/pop, and a push into a full FIFO is accepted only alongside a pop.
module result_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;
  logic             w_push;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/nonce_dispatcher.sv
// Slices a job's nonce range across NUM_CORES lock-step lanes, bounds
// in-flight batches, and queues winning nonces for the serial handler.
module nonce_dispatcher
  import miner_pkg::*;
#(
  parameter int unsigned NUM_CORES    = 4,
  parameter int unsigned NONCE_W      = DEF_NONCE_W,
  parameter int unsigned HASH_W       = DEF_HASH_W,
  parameter int unsigned MAX_INFLIGHT = 8,
  parameter int unsigned RESULT_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         work_restart,
  input  logic                         new_work,
  input  logic [HASH_W-1:0]            work_target,
  input  logic [NONCE_W-1:0]           nonce_start,
  input  logic [NONCE_W-1:0]           nonce_end,
  output logic                         got_work,
  output logic                         exhausted,
  output logic                         core_flush,
  input  logic                         core_ready,
  output logic                         core_issue,
  output logic [NUM_CORES-1:0]         core_lane_en,
  output logic [NUM_CORES*NONCE_W-1:0] core_nonce,
  input  logic                         core_out_valid,
  input  logic [NUM_CORES-1:0]         core_out_en,
  input  logic [NUM_CORES*NONCE_W-1:0] core_out_nonce,
  input  logic [NUM_CORES*HASH_W-1:0]  core_out_hash,
  output logic                         result_valid,
  output logic [NONCE_W-1:0]           result_nonce,
  input  logic                         result_ready,
  output logic                         hit_overflow
);

  localparam int unsigned OW = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned BW = NONCE_W + 1;

  state_t                       r_state;
  logic [HASH_W-1:0]            r_target;
  logic [NONCE_W-1:0]           r_end;
  logic [BW-1:0]                r_base;
  logic [OW-1:0]                r_outstanding;
  logic                         r_got_work;
  logic                         r_exhausted;
  logic                         r_core_flush;
  logic                         r_hit_overflow;
  logic [NUM_CORES-1:0]         r_lane_en;
  logic [NUM_CORES*NONCE_W-1:0] r_core_nonce;

  logic                         w_ctl;
  logic                         w_issue;
  logic                         w_ret;
  logic [OW-1:0]                w_out_next;
  logic [BW-1:0]                w_base_next;
  logic                         w_last_batch;
  logic [BW-1:0]                w_load_base;
  logic [NONCE_W-1:0]           w_load_end;
  logic [BW-1:0]                w_lane_sum;
  logic [NUM_CORES-1:0]         w_lane_en;
  logic [NUM_CORES*NONCE_W-1:0] w_lane_nonce;
  logic [NUM_CORES-1:0]         w_hit;
  logic [3:0]                   w_win_idx;
  logic [NONCE_W-1:0]           w_win_nonce;
  logic                         w_push;
  logic                         w_multi;
  logic                         w_pop;
  logic                         w_drop;
  logic                         w_fifo_full;
  logic                         w_fifo_empty;

  // Job control pre-empts any issue or hit in the same cycle.
  assign w_ctl        = new_work | work_restart;
  assign w_issue      = (r_state == ST_RUN) & core_ready &
                        (r_outstanding < OW'(MAX_INFLIGHT)) & ~w_ctl;
  assign w_ret        = core_out_valid & (r_outstanding != '0);
  assign w_out_next   = r_outstanding + OW'(w_issue) - OW'(w_ret);
  assign w_base_next  = r_base + BW'(NUM_CORES);
  assign w_last_batch = w_base_next > {1'b0, r_end};
  assign w_load_base  = new_work ? {1'b0, nonce_start} : w_base_next;
  assign w_load_end   = new_work ? nonce_end : r_end;

  // Lane contents for the next batch, precomputed so they are registered
  // and valid in the cycle the batch is offered.
  always_comb begin
    w_lane_sum   = '0;
    w_lane_en    = '0;
    w_lane_nonce = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      w_lane_sum                       = w_load_base + BW'(i);
      w_lane_nonce[i*NONCE_W +: NONCE_W] = w_lane_sum[NONCE_W-1:0];
      w_lane_en[i]                     = w_lane_sum <= {1'b0, w_load_end};
    end
  end

  always_comb begin
    w_hit       = '0;
    w_win_nonce = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      w_hit[i] = core_out_valid & core_out_en[i] &
                 ((r_state == ST_RUN) | (r_state == ST_DRAIN)) &
                 hash_le_target(MAX_HASH_W'(core_out_hash[i*HASH_W +: HASH_W]),
                                MAX_HASH_W'(r_target));
    end
    w_win_idx = lowest_set(MAX_LANES'(w_hit));
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (4'(i) == w_win_idx) w_win_nonce = core_out_nonce[i*NONCE_W +: NONCE_W];
    end
  end

  assign w_push  = |w_hit;
  assign w_multi = |(w_hit & (w_hit - NUM_CORES'(1)));
  assign w_pop   = result_ready & ~w_fifo_empty;
  assign w_drop  = w_push & w_fifo_full & ~w_pop;

  result_fifo #(
    .WIDTH (NONCE_W),
    .DEPTH (RESULT_DEPTH)
  ) u_result_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_ctl),
    .i_push  (w_push),
    .i_data  (w_win_nonce),
    .i_pop   (result_ready),
    .o_data  (result_nonce),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_target       <= '0;
      r_end          <= '0;
      r_base         <= '0;
      r_outstanding  <= '0;
      r_got_work     <= 1'b0;
      r_exhausted    <= 1'b0;
      r_core_flush   <= 1'b0;
      r_hit_overflow <= 1'b0;
      r_lane_en      <= '0;
      r_core_nonce   <= '0;
    end else begin
      r_got_work   <= 1'b0;
      r_exhausted  <= 1'b0;
      r_core_flush <= 1'b0;
      if (new_work) begin
        r_state        <= ST_RUN;
        r_target       <= work_target;
        r_end          <= nonce_end;
        r_base         <= {1'b0, nonce_start};
        r_lane_en      <= w_lane_en;
        r_core_nonce   <= w_lane_nonce;
        r_outstanding  <= '0;
        r_got_work     <= 1'b1;
        r_core_flush   <= 1'b1;
        r_hit_overflow <= 1'b0;
      end else if (work_restart) begin
        r_state       <= ST_IDLE;
        r_outstanding <= '0;
        r_core_flush  <= 1'b1;
      end else begin
        r_outstanding <= w_out_next;
        if (w_multi || w_drop) r_hit_overflow <= 1'b1;
        unique case (r_state)
          ST_IDLE: ;
          ST_RUN: begin
            if (w_issue) begin
              r_base       <= w_base_next;
              r_lane_en    <= w_lane_en;
              r_core_nonce <= w_lane_nonce;
              if (w_last_batch) r_state <= ST_DRAIN;
            end
          end
          ST_DRAIN: if (w_out_next == '0) r_state <= ST_DONE;
          ST_DONE: begin
            r_state     <= ST_IDLE;
            r_exhausted <= 1'b1;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign got_work     = r_got_work;
  assign exhausted    = r_exhausted;
  assign core_flush   = r_core_flush;
  assign core_issue   = w_issue;
  assign core_lane_en = r_lane_en;
  assign core_nonce   = r_core_nonce;
  assign result_valid = ~w_fifo_empty;
  assign hit_overflow = r_hit_overflow;

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Scoreboard bench for nonce_dispatcher: directed jobs push expected batches
// and results into queues; a negedge monitor pops and compares.
module tb_nonce_dispatcher;

  localparam int NC = 4;
  localparam int NW = 32;
  localparam int HW = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             work_restart = 1'b0;
  logic             new_work = 1'b0;
  logic [HW-1:0]    work_target = '0;
  logic [NW-1:0]    nonce_start = '0;
  logic [NW-1:0]    nonce_end = '0;
  logic             got_work;
  logic             exhausted;
  logic             core_flush;
  logic             core_ready = 1'b1;
  logic             core_issue;
  logic [NC-1:0]    core_lane_en;
  logic [NC*NW-1:0] core_nonce;
  logic             core_out_valid = 1'b0;
  logic [NC-1:0]    core_out_en = '0;
  logic [NC*NW-1:0] core_out_nonce = '0;
  logic [NC*HW-1:0] core_out_hash = '0;
  logic             result_valid;
  logic [NW-1:0]    result_nonce;
  logic             result_ready = 1'b1;
  logic             hit_overflow;

  always #5 clk = ~clk;

  typedef struct { bit v; logic [NC-1:0] en; logic [NC*NW-1:0] nonce; } batch_t;
  typedef struct { logic [NW-1:0] base; logic [NC-1:0] en; } iss_t;

  iss_t            exp_iss_q[$];
  logic [NW-1:0]   exp_res_q[$];
  batch_t          held_q[$];
  logic [HW-1:0]   hit_tbl [logic [NW-1:0]];
  logic [HW-1:0]   dflt_hash = '1;
  int              n_chk = 0;
  int              n_err = 0;
  int              exh_cnt = 0;
  int              iss_cnt = 0;
  bit              model_on = 1'b1;
  bit              release_held = 1'b0;
  batch_t          cap = '{v: 1'b0, en: '0, nonce: '0};
  batch_t          slot0 = '{v: 1'b0, en: '0, nonce: '0};
  batch_t          slot1 = '{v: 1'b0, en: '0, nonce: '0};

  nonce_dispatcher #(
    .NUM_CORES    (NC),
    .NONCE_W      (NW),
    .HASH_W       (HW),
    .MAX_INFLIGHT (8),
    .RESULT_DEPTH (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .work_restart   (work_restart),
    .new_work       (new_work),
    .work_target    (work_target),
    .nonce_start    (nonce_start),
    .nonce_end      (nonce_end),
    .got_work       (got_work),
    .exhausted      (exhausted),
    .core_flush     (core_flush),
    .core_ready     (core_ready),
    .core_issue     (core_issue),
    .core_lane_en   (core_lane_en),
    .core_nonce     (core_nonce),
    .core_out_valid (core_out_valid),
    .core_out_en    (core_out_en),
    .core_out_nonce (core_out_nonce),
    .core_out_hash  (core_out_hash),
    .result_valid   (result_valid),
    .result_nonce   (result_nonce),
    .result_ready   (result_ready),
    .hit_overflow   (hit_overflow)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NC*HW-1:0] lane_hashes(input logic [NC*NW-1:0] n);
    logic [NC*HW-1:0] h;
    logic [NW-1:0]    x;
    h = '0;
    for (int i = 0; i < NC; i++) begin
      x = n[i*NW +: NW];
      h[i*HW +: HW] = hit_tbl.exists(x) ? hit_tbl[x] : dflt_hash;
    end
    return h;
  endfunction

  // Monitor: scoreboard pops on issue / result pop, counts exhausted pulses.
  always @(negedge clk) begin
    iss_t          e;
    logic [NW-1:0] en_n;
    logic [NW-1:0] r;
    if (rst) begin
      cap.v = 1'b0;
    end else begin
      cap.v     = core_issue;
      cap.en    = core_lane_en;
      cap.nonce = core_nonce;
      if (core_issue) begin
        iss_cnt++;
        if (exp_iss_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_issue: got base 0x%0h en %b, expected no issue",
                   core_nonce[NW-1:0], core_lane_en);
        end else begin
          e = exp_iss_q.pop_front();
          chk("issue_lane_en", core_lane_en, e.en);
          for (int i = 0; i < NC; i++) begin
            en_n = e.base + NW'(i);
            if (e.en[i]) chk("issue_nonce", core_nonce[i*NW +: NW], en_n);
          end
        end
      end
      if (result_valid && result_ready) begin
        if (exp_res_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_result: got 0x%0h, expected none", result_nonce);
        end else begin
          r = exp_res_q.pop_front();
          chk("result_nonce", result_nonce, r);
        end
      end
      if (exhausted) exh_cnt++;
    end
  end

  // 3-cycle lock-step core model; batches issued while model_on=0 are held
  // back and replayed later as stale returns when release_held is set.
  always @(posedge clk) begin
    batch_t o;
    #1;
    o     = slot1;
    slot1 = slot0;
    slot0 = cap;
    slot0.v = cap.v && model_on;
    if (cap.v && !model_on) held_q.push_back(cap);
    cap.v = 1'b0;
    if (!o.v && release_held && held_q.size() > 0) o = held_q.pop_front();
    core_out_valid = o.v;
    core_out_en    = o.v ? o.en : '0;
    core_out_nonce = o.v ? o.nonce : '0;
    core_out_hash  = o.v ? lane_hashes(o.nonce) : '0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_iss(input logic [NW-1:0] base, input logic [NC-1:0] en);
    iss_t e;
    e.base = base;
    e.en   = en;
    exp_iss_q.push_back(e);
  endtask

  task automatic start_job(input logic [NW-1:0] s, input logic [NW-1:0] e,
                           input logic [HW-1:0] tgt);
    nonce_start = s;
    nonce_end   = e;
    work_target = tgt;
    new_work    = 1'b1;
    step();
    new_work = 1'b0;
    @(negedge clk);
    chk("got_work_pulse", got_work, 1);
    chk("core_flush_on_new_work", core_flush, 1);
  endtask

  task automatic wait_exh(input int target, input int budget);
    for (int i = 0; i < budget && exh_cnt < target; i++) @(negedge clk);
    chk("exhausted_count", exh_cnt, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  iss0;
    bit  seen_rv;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_got_work", got_work, 0);
    chk("rst_exhausted", exhausted, 0);
    chk("rst_core_flush", core_flush, 0);
    chk("rst_core_issue", core_issue, 0);
    chk("rst_lane_en", core_lane_en, 0);
    chk("rst_core_nonce", core_nonce, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_result_nonce", result_nonce, 0);
    chk("rst_hit_overflow", hit_overflow, 0);

    // Range 0..9: batches at 0, 4, 8; last batch only lanes 0,1.
    push_iss(32'd0, 4'b1111);
    push_iss(32'd4, 4'b1111);
    push_iss(32'd8, 4'b0011);
    start_job(32'd0, 32'd9, 32'd0);
    wait_exh(1, 100);
    repeat (10) step();
    chk("t1_exhausted_once", exh_cnt, 1);
    chk("t1_issue_count", iss_cnt, 3);

    // Top of the nonce space: one partial batch, no wrap to zero.
    push_iss(32'hFFFF_FFFE, 4'b0011);
    start_job(32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0);
    wait_exh(2, 100);
    repeat (10) step();
    chk("t2_issue_count", iss_cnt, 4);

    // Single hit on lane 2 at target boundary.
    dflt_hash    = 32'h0000_0101;
    hit_tbl[2]   = 32'h0000_00FF;
    result_ready = 1'b0;
    push_iss(32'd0, 4'b1111);
    start_job(32'd0, 32'd3, 32'h0000_0100);
    wait_exh(3, 100);
    step();
    @(negedge clk);
    chk("t3_result_valid", result_valid, 1);
    chk("t3_result_head", result_nonce, 2);
    chk("t3_no_overflow", hit_overflow, 0);
    exp_res_q.push_back(32'd2);
    step();
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    @(negedge clk);
    chk("t3_single_entry", result_valid, 0);

    // Simultaneous hits on lanes 1 and 3.
    hit_tbl.delete();
    dflt_hash    = '1;
    hit_tbl[17]  = '0;
    hit_tbl[19]  = '0;
    result_ready = 1'b1;
    push_iss(32'd16, 4'b1111);
    exp_res_q.push_back(32'd17);
    start_job(32'd16, 32'd19, 32'h10);
    wait_exh(4, 100);
    repeat (3) step();
    @(negedge clk);
    chk("t4_overflow_set", hit_overflow, 1);
    chk("t4_result_popped", exp_res_q.size(), 0);
    hit_tbl.delete();
    push_iss(32'd0, 4'b1111);
    start_job(32'd0, 32'd3, 32'h10);
    chk("t4_overflow_cleared", hit_overflow, 0);
    wait_exh(5, 100);
    repeat (5) step();

    // Cores never return: stall at 8 outstanding, then restart.
    model_on   = 1'b0;
    hit_tbl[5] = '0;
    for (int k = 0; k < 8; k++) push_iss(32'(4 * k), 4'b1111);
    iss0 = iss_cnt;
    start_job(32'd0, 32'd1000, 32'h10);
    repeat (20) step();
    @(negedge clk);
    chk("t5_inflight_limit", iss_cnt - iss0, 8);
    chk("t5_stalled", core_issue, 0);
    step();
    work_restart = 1'b1;
    step();
    work_restart = 1'b0;
    @(negedge clk);
    chk("t5_restart_flush", core_flush, 1);
    chk("t5_restart_no_got_work", got_work, 0);
    release_held = 1'b1;
    seen_rv = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      @(negedge clk);
      seen_rv |= result_valid;
    end
    chk("t5_late_returns_ignored", seen_rv, 0);
    chk("t5_late_returns_sent", held_q.size(), 0);
    chk("t5_no_exhausted", exh_cnt, 5);
    release_held = 1'b0;
    model_on     = 1'b1;

    // Nine hits against an 8-deep FIFO with no pops.
    hit_tbl.delete();
    for (int k = 0; k < 9; k++) hit_tbl[32'(4 * k + 1)] = '0;
    result_ready = 1'b0;
    for (int k = 0; k < 9; k++) push_iss(32'(4 * k), 4'b1111);
    start_job(32'd0, 32'd35, 32'h10);
    wait_exh(6, 200);
    step();
    @(negedge clk);
    chk("t6_overflow_set", hit_overflow, 1);
    chk("t6_result_valid", result_valid, 1);
    chk("t6_result_head", result_nonce, 1);
    for (int k = 0; k < 8; k++) exp_res_q.push_back(32'(4 * k + 1));
    step();
    result_ready = 1'b1;
    repeat (12) step();
    @(negedge clk);
    chk("t6_fifo_drained", result_valid, 0);
    chk("t6_all_results_seen", exp_res_q.size(), 0);
    chk("all_issues_seen", exp_iss_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
